rom_arbiter: RTL

Two-port arbiter and read sequencer for the single-port instruction ROM (16-bit address, 16-bit word, byte-addressed, 2-byte instruction slots). It shares the ROM read port between the instruction-fetch requester and a data-load requester (constant/table reads from program memory). Accesses are pipelined, one per cycle, and return registered data after a fixed latency. Fetch has priority, with a bounded starvation guard for loads and a flush that discards in-flight fetches on a taken branch or jump.

---
 rtl/rom_arbiter_if.sv | 36 +++
 rtl/rom_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester and ROM port bundle for the instruction ROM arbiter

interface rom_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [15:0] if_data;
    logic        if_err;

    logic        ld_req;
    logic [15:0] ld_addr;
    logic        ld_gnt;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_err;

    logic        flush;

    logic [15:0] rom_addr;
    logic [15:0] rom_data;

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, flush, rom_data,
        output if_gnt, if_valid, if_data, if_err,
        output ld_gnt, ld_valid, ld_data, ld_err,
        output rom_addr
    );

    modport master (
        output if_req, if_addr, ld_req, ld_addr, flush, rom_data,
        input  if_gnt, if_valid, if_data, if_err,
        input  ld_gnt, ld_valid, ld_data, ld_err,
        input  rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - fetch/load arbiter and 2-stage read pipeline for the instruction ROM

module rom_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt;
    logic        if_gnt;
    logic        ld_gnt;
    logic        any_gnt;
    logic [15:0] gnt_addr;

    logic        s1_valid;
    logic        s1_ld;
    logic        s1_err;
    logic        s1_live;
    logic [15:0] rom_addr_q;

    logic        s2_if_valid;
    logic        s2_ld_valid;
    logic [15:0] if_data_q;
    logic        if_err_q;
    logic [15:0] ld_data_q;
    logic        ld_err_q;
    logic [15:0] resp_word;

    // Fetch has priority unless the load has waited out its starvation budget.
    always_comb begin
        if_gnt = 1'b0;
        ld_gnt = 1'b0;
        if (bus.flush) begin
            ld_gnt = bus.ld_req;
        end else if ((starve_cnt == LIMIT) && bus.ld_req) begin
            ld_gnt = 1'b1;
        end else if (bus.if_req) begin
            if_gnt = 1'b1;
        end else begin
            ld_gnt = bus.ld_req;
        end
    end

    assign any_gnt  = if_gnt | ld_gnt;
    assign gnt_addr = ld_gnt ? bus.ld_addr : bus.if_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!bus.ld_req || ld_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // S1: registered ROM address plus owner and misalignment tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_ld      <= 1'b0;
            s1_err     <= 1'b0;
            rom_addr_q <= 16'h0000;
        end else begin
            s1_valid <= any_gnt;
            if (any_gnt) begin
                s1_ld      <= ld_gnt;
                s1_err     <= gnt_addr[0];
                rom_addr_q <= {gnt_addr[15:1], 1'b0};
            end
        end
    end

    // A flush kills a fetch sitting in S1 before its data is captured.
    assign s1_live   = s1_valid & ~(bus.flush & ~s1_ld);
    assign resp_word = s1_err ? 16'h0000 : bus.rom_data;

    // S2: per-requester response registers; data only moves when its owner completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_if_valid <= 1'b0;
            s2_ld_valid <= 1'b0;
            if_data_q   <= 16'h0000;
            if_err_q    <= 1'b0;
            ld_data_q   <= 16'h0000;
            ld_err_q    <= 1'b0;
        end else begin
            s2_if_valid <= s1_live & ~s1_ld;
            s2_ld_valid <= s1_live & s1_ld;
            if (s1_live && !s1_ld) begin
                if_data_q <= resp_word;
                if_err_q  <= s1_err;
            end
            if (s1_live && s1_ld) begin
                ld_data_q <= resp_word;
                ld_err_q  <= s1_err;
            end
        end
    end

    assign bus.if_gnt   = if_gnt;
    assign bus.ld_gnt   = ld_gnt;
    assign bus.rom_addr = rom_addr_q;

    // A fetch already in S2 is presented this cycle, so flush must mask it here.
    assign bus.if_valid = s2_if_valid & ~bus.flush;
    assign bus.if_data  = if_data_q;
    assign bus.if_err   = if_err_q;
    assign bus.ld_valid = s2_ld_valid;
    assign bus.ld_data  = ld_data_q;
    assign bus.ld_err   = ld_err_q;

    a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
        !(if_gnt && ld_gnt));

    a_one_valid : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.if_valid && bus.ld_valid));

endmodule
